// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared CPU-wide constants and register-file types.
//   REG_DATA_W : architectural register width
//   REG_ADDR_W : register index width
//   XZR_IDX    : index of the hardwired zero register
//   reg_addr_t / reg_data_t : register index / value types
package cpu_pkg;

    localparam int REG_DATA_W = 64;
    localparam int REG_ADDR_W = 5;
    localparam int XZR_IDX    = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/decoder_5_32.sv
// decoder_5_32
// 5-to-32 one-hot decoder with enable.
//   en     : in  1  when low, every output bit is 0
//   addr   : in  5  index to decode
//   onehot : out 32 bit [addr] set when en is high
module decoder_5_32
    import cpu_pkg::*;
(
    input  logic        en,
    input  reg_addr_t   addr,
    output logic [31:0] onehot
);

    // Plain one-hot decode; nothing is selected unless enabled.
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/mux32_1.sv
// mux32_1
// 32-to-1 multiplexer of W-bit words.
//   dataIn  : in  32 x W  candidate words, word i at index i
//   sel     : in  5       selected word index
//   dataOut : out W       dataIn[sel]
module mux32_1 #(
    parameter int W = 64
) (
    input  logic [31:0][W-1:0] dataIn,
    input  logic [4:0]         sel,
    output logic [W-1:0]       dataOut
);

    // Straight array select.
    assign dataOut = dataIn[sel];

endmodule

// File: rtl/regfile_read_port.sv
// regfile_read_port
// One combinational read port of the scoreboarded register file.
//   reset   : in  1               while high, the port reads 0 and not busy
//   regs    : in  DEPTH x DATA_W  register storage
//   pending : in  DEPTH           scoreboard pending bits
//   wrEn/wrAddr/wrData : in       writeback port, used for same-cycle bypass
//   rdAddr  : in  ADDR_W          address read by this port
//   rdData  : out DATA_W          read value
//   rdBusy  : out 1               register still owed by an in-flight producer
module regfile_read_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DEPTH    = 2**ADDR_W,
    parameter int ZERO_REG = XZR_IDX
) (
    input  logic                          reset,
    input  logic [DEPTH-1:0][DATA_W-1:0]  regs,
    input  logic [DEPTH-1:0]              pending,
    input  logic                          wrEn,
    input  logic [ADDR_W-1:0]             wrAddr,
    input  logic [DATA_W-1:0]             wrData,
    input  logic [ADDR_W-1:0]             rdAddr,
    output logic [DATA_W-1:0]             rdData,
    output logic                          rdBusy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] storeData;

    // Storage lookup: reuse the library mux for the standard 32-entry file.
    generate
        if (ADDR_W == 5) begin : gen_mux32
            mux32_1 #(.W(DATA_W)) uMux (
                .dataIn  (regs),
                .sel     (rdAddr),
                .dataOut (storeData)
            );
        end else begin : gen_mux_generic
            assign storeData = regs[rdAddr];
        end
    endgenerate

    // Zero register and reset win; then a writeback to the same address is
    // forwarded, and because that write is the producer arriving, the read
    // is no longer busy. Otherwise storage and scoreboard are reported as is.
    always_comb begin
        rdData = '0;
        rdBusy = 1'b0;
        if (reset || rdAddr == ZERO_ADDR) begin
            rdData = '0;
            rdBusy = 1'b0;
        end else if (wrEn && wrAddr == rdAddr) begin
            rdData = wrData;
        end else begin
            rdData = storeData;
            rdBusy = pending[rdAddr];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Register file with NUM_READ combinational read ports, one write port,
// same-cycle write-to-read bypass and a per-register pending scoreboard.
//   clk        : in  1                 rising-edge clock
//   reset      : in  1                 async active-high; clears storage and pending
//   rd_addr    : in  NUM_READ*ADDR_W   port p at [p*ADDR_W +: ADDR_W]
//   rd_data    : out NUM_READ*DATA_W   port p at [p*DATA_W +: DATA_W]
//   rd_busy    : out NUM_READ          addressed register still pending
//   wr_en/wr_addr/wr_data : in         writeback port; also releases pending
//   claim_en/claim_addr   : in         decode marks a destination pending
//   flush      : in  1                 clear all pending bits, keep data
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = XZR_IDX
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_READ*ADDR_W-1:0]   rd_addr,
    output logic [NUM_READ*DATA_W-1:0]   rd_data,
    output logic [NUM_READ-1:0]          rd_busy,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         claim_en,
    input  logic [ADDR_W-1:0]            claim_addr,
    input  logic                         flush
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             pending;
    logic [DEPTH-1:0]             wrSel;
    logic [DEPTH-1:0]             wrMask;
    logic [DEPTH-1:0]             claimMask;

    // Write-address decode: library decoder for the standard 32-entry file.
    generate
        if (ADDR_W == 5) begin : gen_dec32
            decoder_5_32 uWrDec (
                .en     (wr_en),
                .addr   (wr_addr),
                .onehot (wrSel)
            );
        end else begin : gen_dec_generic
            always_comb begin
                wrSel = '0;
                if (wr_en) wrSel[wr_addr] = 1'b1;
            end
        end
    endgenerate

    // The zero register can be neither written nor claimed, so it is simply
    // removed from both one-hot masks and its flops stay at their reset value.
    always_comb begin
        wrMask = wrSel;
        wrMask[ZERO_REG] = 1'b0;
        claimMask = '0;
        if (claim_en) claimMask[claim_addr] = 1'b1;
        claimMask[ZERO_REG] = 1'b0;
    end

    // Storage and scoreboard. A claim always sets its bit (a new producer
    // owns the register even if it is being written or flushed this cycle);
    // otherwise a write releases the bit and a flush releases all of them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs    <= '0;
            pending <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wrMask[i]) regs[i] <= wr_data;
            end
            pending <= claimMask | (flush ? '0 : (pending & ~wrSel));
        end
    end

    // One independent combinational read port per requested port.
    generate
        for (genvar p = 0; p < NUM_READ; p++) begin : gen_read
            regfile_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .DEPTH    (DEPTH),
                .ZERO_REG (ZERO_REG)
            ) uReadPort (
                .reset   (reset),
                .regs    (regs),
                .pending (pending),
                .wrEn    (wr_en),
                .wrAddr  (wr_addr),
                .wrData  (wr_data),
                .rdAddr  (rd_addr[p*ADDR_W +: ADDR_W]),
                .rdData  (rd_data[p*DATA_W +: DATA_W]),
                .rdBusy  (rd_busy[p])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
// Directed self-checking bench for regfile_scoreboard (2 read ports).
// Inputs change 1 time unit after a rising edge; outputs are sampled a
// couple of units later, well away from the next edge.
module tb_regfile_scoreboard;

    logic         clk;
    logic         reset;
    logic [9:0]   rd_addr;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [63:0]  wr_data;
    logic         claim_en;
    logic [4:0]   claim_addr;
    logic         flush;

    int passCount  = 0;
    int checkCount = 0;

    localparam logic [63:0] BEEF = 64'hDEAD_BEEF_0000_0001;

    wire [63:0] data0 = rd_data[63:0];
    wire [63:0] data1 = rd_data[127:64];
    wire        busy0 = rd_busy[0];
    wire        busy1 = rd_busy[1];

    regfile_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .flush      (flush)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleInputs();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
        flush      = 1'b0;
    endtask

    task automatic setRead(input logic [4:0] a0, input logic [4:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Every address reads 0 / not busy on both ports after reset.
    task automatic test_reset();
        for (int a = 0; a < 32; a++) begin
            setRead(5'(a), 5'(a));
            #1;
            checkCount++;
            if (data0 !== 64'h0 || busy0 !== 1'b0)
                $display("[TB] FAIL reset_p0 a=%0d: got data=%h busy=%b, want data=0 busy=0", a, data0, busy0);
            else passCount++;
            checkCount++;
            if (data1 !== 64'h0 || busy1 !== 1'b0)
                $display("[TB] FAIL reset_p1 a=%0d: got data=%h busy=%b, want data=0 busy=0", a, data1, busy1);
            else passCount++;
        end
    endtask

    // Write X5 while reading it: bypass now, storage next cycle.
    task automatic test_bypass();
        idleInputs();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = BEEF;
        setRead(5'd5, 5'd5);
        #1;
        checkCount++;
        if (data0 !== BEEF || busy0 !== 1'b0 || data1 !== BEEF || busy1 !== 1'b0)
            $display("[TB] FAIL bypass_same: got %h/%b %h/%b, want %h/0 on both", data0, busy0, data1, busy1, BEEF);
        else passCount++;
        nextCycle();
        idleInputs();
        #1;
        checkCount++;
        if (data0 !== BEEF || busy0 !== 1'b0 || data1 !== BEEF)
            $display("[TB] FAIL bypass_next: got %h/%b %h, want %h/0", data0, busy0, data1, BEEF);
        else passCount++;
    endtask

    // Writes and claims to X31 are ignored.
    task automatic test_zero_reg();
        idleInputs();
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        claim_en = 1'b1; claim_addr = 5'd31;
        setRead(5'd31, 5'd31);
        #1;
        checkCount++;
        if (rd_data !== 128'h0 || rd_busy !== 2'b00)
            $display("[TB] FAIL zero_same: got data=%h busy=%b, want 0/00", rd_data, rd_busy);
        else passCount++;
        nextCycle();
        idleInputs();
        #1;
        checkCount++;
        if (rd_data !== 128'h0 || rd_busy !== 2'b00)
            $display("[TB] FAIL zero_after: got data=%h busy=%b, want 0/00", rd_data, rd_busy);
        else passCount++;
    endtask

    // Claim X7, stay busy for three cycles, release by writing 0x42.
    task automatic test_claim_release();
        idleInputs();
        claim_en = 1'b1; claim_addr = 5'd7;
        setRead(5'd7, 5'd7);
        #1;
        checkCount++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0)
            $display("[TB] FAIL claim_c0: got busy=%b%b, want 00", busy1, busy0);
        else passCount++;
        nextCycle();
        idleInputs();
        for (int c = 1; c <= 3; c++) begin
            #1;
            checkCount++;
            if (busy0 !== 1'b1 || busy1 !== 1'b1 || data0 !== 64'h0)
                $display("[TB] FAIL claim_c%0d: got busy=%b%b data=%h, want 11 data=0", c, busy1, busy0, data0);
            else passCount++;
            nextCycle();
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h42;
        #1;
        checkCount++;
        if (busy0 !== 1'b0 || data0 !== 64'h42 || busy1 !== 1'b0)
            $display("[TB] FAIL claim_c4: got busy=%b%b data=%h, want 00 data=42", busy1, busy0, data0);
        else passCount++;
        nextCycle();
        idleInputs();
        #1;
        checkCount++;
        if (busy0 !== 1'b0 || data0 !== 64'h42)
            $display("[TB] FAIL claim_c5: got busy=%b data=%h, want 0 data=42", busy0, data0);
        else passCount++;
    endtask

    // Same-cycle claim and write of X9: claim wins, data lands.
    task automatic test_claim_write_same();
        idleInputs();
        claim_en = 1'b1; claim_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h11;
        setRead(5'd9, 5'd5);
        nextCycle();
        idleInputs();
        #1;
        checkCount++;
        if (data0 !== 64'h11 || busy0 !== 1'b1)
            $display("[TB] FAIL claim_write: got data=%h busy=%b, want 11/1", data0, busy0);
        else passCount++;
        checkCount++;
        if (data1 !== BEEF || busy1 !== 1'b0)
            $display("[TB] FAIL claim_write_other: got data=%h busy=%b, want %h/0", data1, busy1, BEEF);
        else passCount++;
    endtask

    // Claim X1..X3, then flush while claiming X4.
    task automatic test_flush();
        idleInputs();
        for (int r = 1; r <= 3; r++) begin
            claim_en = 1'b1; claim_addr = 5'(r);
            nextCycle();
        end
        claim_addr = 5'd4; flush = 1'b1;
        setRead(5'd1, 5'd2);
        #1;
        checkCount++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1)
            $display("[TB] FAIL flush_before: got busy=%b%b, want 11", busy1, busy0);
        else passCount++;
        nextCycle();
        idleInputs();
        #1;
        checkCount++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0)
            $display("[TB] FAIL flush_x1x2: got busy=%b%b, want 00", busy1, busy0);
        else passCount++;
        setRead(5'd3, 5'd4);
        #1;
        checkCount++;
        if (busy0 !== 1'b0 || busy1 !== 1'b1)
            $display("[TB] FAIL flush_x3x4: got busy=%b%b, want 10", busy1, busy0);
        else passCount++;
        setRead(5'd9, 5'd9);
        #1;
        checkCount++;
        if (busy0 !== 1'b0 || data0 !== 64'h11)
            $display("[TB] FAIL flush_keep_data: got busy=%b data=%h, want 0/11", busy0, data0);
        else passCount++;
    endtask

    // Consecutive writes; storage on one port, bypass on the other.
    task automatic test_back_to_back();
        idleInputs();
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 64'hA0A0;
        nextCycle();
        wr_addr = 5'd11; wr_data = 64'hB1B1;
        setRead(5'd10, 5'd11);
        #1;
        checkCount++;
        if (data0 !== 64'hA0A0 || data1 !== 64'hB1B1 || rd_busy !== 2'b00)
            $display("[TB] FAIL b2b_same: got %h %h busy=%b, want a0a0 b1b1 00", data0, data1, rd_busy);
        else passCount++;
        nextCycle();
        idleInputs();
        #1;
        checkCount++;
        if (data0 !== 64'hA0A0 || data1 !== 64'hB1B1 || rd_busy !== 2'b00)
            $display("[TB] FAIL b2b_next: got %h %h busy=%b, want a0a0 b1b1 00", data0, data1, rd_busy);
        else passCount++;
    endtask

    // Reset between edges clears outputs immediately and wipes storage.
    task automatic test_async_reset();
        idleInputs();
        setRead(5'd5, 5'd4);
        #1;
        checkCount++;
        if (data0 !== BEEF || busy1 !== 1'b1)
            $display("[TB] FAIL areset_pre: got data=%h busy=%b, want %h/1", data0, busy1, BEEF);
        else passCount++;
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 64'h77;
        setRead(5'd5, 5'd6);
        #1;
        reset = 1'b1;
        #1;
        checkCount++;
        if (rd_data !== 128'h0 || rd_busy !== 2'b00)
            $display("[TB] FAIL areset_during: got data=%h busy=%b, want 0/00", rd_data, rd_busy);
        else passCount++;
        #1;
        reset = 1'b0;
        idleInputs();
        setRead(5'd5, 5'd4);
        nextCycle();
        checkCount++;
        if (data0 !== 64'h0 || data1 !== 64'h0 || rd_busy !== 2'b00)
            $display("[TB] FAIL areset_after: got %h %h busy=%b, want 0 0 00", data0, data1, rd_busy);
        else passCount++;
    endtask

    initial begin
        idleInputs();
        rd_addr = '0;
        reset = 1'b1;
        #12;
        reset = 1'b0;
        test_reset();
        nextCycle();
        test_bypass();
        nextCycle();
        test_zero_reg();
        nextCycle();
        test_claim_release();
        nextCycle();
        test_claim_write_same();
        nextCycle();
        test_flush();
        nextCycle();
        test_back_to_back();
        nextCycle();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
